// File: rtl/updy_pkg.sv
// updy_pkg -- shared types and constants for the change-in-Y stream engine.
//   CW_DEFAULT     default real/imag component width
//   cplx_t         complex word {re, im} at the default width
//   beatKind_e     classification of an input beat (OFF, DIAG, NOP)
//   state_e        change-sequencing FSM states (S_OFF, S_DIAG)
//   satMax/satMin  saturation bounds for a w-bit two's complement component,
//                  returned in 64 bits (callers truncate to w bits)
// Optional feature macro: UPDY_SAT_EN (saturating component arithmetic).
package updy_pkg;

  localparam int CW_DEFAULT = 24;

  typedef struct packed {
    logic [CW_DEFAULT-1:0] re;
    logic [CW_DEFAULT-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    DIAG = 2'd1,
    NOP  = 2'd2
  } beatKind_e;

  typedef enum logic {
    S_OFF  = 1'b0,
    S_DIAG = 1'b1
  } state_e;

  function automatic logic [63:0] satMax(int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Inverting +max gives -2^(w-1) in the low w bits.
  function automatic logic [63:0] satMin(int w);
    return ~satMax(w);
  endfunction

endpackage

// File: rtl/updy_cplx_addsub.sv
// updy_cplx_addsub -- LAT-stage elastic complex add/sub with sideband.
// The operation is applied on load; the result then moves through LAT
// valid/ready stages. A stage loads when it is empty or when everything
// downstream of it can move, so a full pipeline accepts and emits in the
// same cycle.
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   loadValid           beat to load into stage 0 (qualified by loadReady)
//   opA, opB, opSub     operands {re,im}; opSub=1 -> a-b, else a+b
//   kindIn, doneIn      sideband carried with the result
//   loadReady           stage 0 can take a beat this cycle
//   outValid/outReady   output handshake from the last stage
//   outY/outKind/outDone result and sideband, held while stalled
//   anyValid            any stage holds a beat
// Optional feature macro: UPDY_SAT_EN -- components saturate instead of wrap.
module updy_cplx_addsub
  import updy_pkg::*;
#(
  parameter int CW  = CW_DEFAULT,
  parameter int LAT = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          loadValid,
  input  logic [2*CW-1:0] opA,
  input  logic [2*CW-1:0] opB,
  input  logic          opSub,
  input  logic          kindIn,
  input  logic          doneIn,
  output logic          loadReady,
  output logic          outValid,
  input  logic          outReady,
  output logic [2*CW-1:0] outY,
  output logic          outKind,
  output logic          outDone,
  output logic          anyValid
);

`ifdef UPDY_SAT_EN
  localparam logic [CW-1:0] SAT_HI = CW'(satMax(CW));
  localparam logic [CW-1:0] SAT_LO = CW'(satMin(CW));
`endif

  function automatic logic [CW-1:0] compOp(logic [CW-1:0] a, logic [CW-1:0] b, logic sub);
`ifdef UPDY_SAT_EN
    logic [CW:0] s;
    s = sub ? ({a[CW-1], a} - {b[CW-1], b}) : ({a[CW-1], a} + {b[CW-1], b});
    // Top two bits of the sign-extended sum disagree only on overflow.
    if (s[CW] != s[CW-1]) return s[CW] ? SAT_LO : SAT_HI;
    return s[CW-1:0];
`else
    return sub ? (a - b) : (a + b);
`endif
  endfunction

  logic [LAT-1:0]  vld;
  logic [LAT-1:0]  canLoad;
  logic [LAT-1:0]  kindPipe;
  logic [LAT-1:0]  donePipe;
  logic [2*CW-1:0] yPipe [LAT];
  logic [2*CW-1:0] result;

  assign result = {compOp(opA[2*CW-1:CW], opB[2*CW-1:CW], opSub),
                   compOp(opA[CW-1:0],    opB[CW-1:0],    opSub)};

  // Stage k may load if any stage at or after k is empty, or the output drains.
  always_comb begin
    for (int k = 0; k < LAT; k++) begin
      canLoad[k] = outReady;
      for (int j = k; j < LAT; j++) begin
        if (!vld[j]) canLoad[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld      <= '0;
      kindPipe <= '0;
      donePipe <= '0;
      for (int k = 0; k < LAT; k++) yPipe[k] <= '0;
    end else begin
      if (canLoad[0]) begin
        vld[0]      <= loadValid;
        yPipe[0]    <= result;
        kindPipe[0] <= kindIn;
        donePipe[0] <= doneIn;
      end
      for (int k = 1; k < LAT; k++) begin
        if (canLoad[k]) begin
          vld[k]      <= vld[k-1];
          yPipe[k]    <= yPipe[k-1];
          kindPipe[k] <= kindPipe[k-1];
          donePipe[k] <= donePipe[k-1];
        end
      end
    end
  end

  assign loadReady = canLoad[0];
  assign outValid  = vld[LAT-1];
  assign outY      = yPipe[LAT-1];
  assign outKind   = kindPipe[LAT-1];
  assign outDone   = donePipe[LAT-1];
  assign anyValid  = |vld;

endmodule

// File: rtl/updy_stream_engine.sv
// updy_stream_engine -- applies a stream of branch-change beats to Y entries.
// Each change is one off-diagonal beat (y_b != 0) followed by DIAG_PER_CHG
// diagonal beats (y_b == 0, y_a != 0); all-zero beats are consumed silently.
// The change FSM and delta register update on accept, so the next beat in
// the same cycle stream already sees the new delta.
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   in_valid/in_ready        input handshake
//   in_mode                  0 add branch, 1 remove branch (off-diag beats)
//   in_y_a, in_y_b           current entry and branch admittance, {re,im}
//   out_valid/out_ready      output handshake
//   out_y, out_kind          updated entry; kind 0 off-diag, 1 diag
//   out_chg_done             result is the last diagonal of its change
//   err_seq                  one-cycle pulse after an out-of-sequence beat
//   busy                     beats in flight or a change is open
// Optional feature macro: UPDY_SAT_EN -- saturating component arithmetic.
module updy_stream_engine
  import updy_pkg::*;
#(
  parameter int CW           = CW_DEFAULT,
  parameter int ADD_LAT      = 2,
  parameter int DIAG_PER_CHG = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [2*CW-1:0] in_y_a,
  input  logic [2*CW-1:0] in_y_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*CW-1:0] out_y,
  output logic            out_kind,
  output logic            out_chg_done,
  output logic            err_seq,
  output logic            busy
);

  localparam int CNT_W = $clog2(DIAG_PER_CHG + 1);
  localparam logic [CNT_W-1:0] LAST_DIAG = CNT_W'(DIAG_PER_CHG - 1);

  // state  | meaning
  // S_OFF  | no change open; expecting an off-diagonal beat
  // S_DIAG | change open; counting its diagonal beats
  state_e          state;
  logic            mode;
  logic [2*CW-1:0] delta;
  logic [CNT_W-1:0] count;
  logic            errSeqQ;

  beatKind_e       kind;
  logic            accept;
  logic [2*CW-1:0] opB;
  logic            opSub;
  logic            beatDone;
  logic            seqErr;
  logic            pipeBusy;

  always_comb begin
    if (in_y_b != '0)      kind = OFF;
    else if (in_y_a != '0) kind = DIAG;
    else                   kind = NOP;
  end

  assign accept = in_valid & in_ready;

  // A diagonal outside a change passes through unchanged (b = 0, add).
  always_comb begin
    opB      = '0;
    opSub    = 1'b0;
    beatDone = 1'b0;
    seqErr   = 1'b0;
    case (kind)
      OFF: begin
        opB    = in_y_b;
        opSub  = ~in_mode;
        seqErr = (state == S_DIAG);
      end
      DIAG: begin
        if (state == S_DIAG) begin
          opB      = delta;
          opSub    = mode;
          beatDone = (count == LAST_DIAG);
        end else begin
          seqErr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_OFF;
      mode    <= 1'b0;
      delta   <= '0;
      count   <= '0;
      errSeqQ <= 1'b0;
    end else begin
      errSeqQ <= accept & seqErr;
      if (accept) begin
        if (kind == OFF) begin
          delta <= in_y_b;
          mode  <= in_mode;
          count <= '0;
          state <= S_DIAG;
        end else if (kind == DIAG && state == S_DIAG) begin
          if (beatDone) begin
            delta <= '0;
            count <= '0;
            state <= S_OFF;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
      end
    end
  end

  // Stage 0 only loads when it can, so loadValid need not include in_ready.
  updy_cplx_addsub #(
    .CW  (CW),
    .LAT (ADD_LAT)
  ) uAddSub (
    .clock     (clock),
    .reset     (reset),
    .loadValid (in_valid & (kind != NOP)),
    .opA       (in_y_a),
    .opB       (opB),
    .opSub     (opSub),
    .kindIn    (kind == DIAG),
    .doneIn    (beatDone),
    .loadReady (in_ready),
    .outValid  (out_valid),
    .outReady  (out_ready),
    .outY      (out_y),
    .outKind   (out_kind),
    .outDone   (out_chg_done),
    .anyValid  (pipeBusy)
  );

  assign err_seq = errSeqQ;
  assign busy    = pipeBusy | (state != S_OFF);

endmodule

// File: tb/tb_updy_stream_engine.sv
`timescale 1ns/1ps
module tb_updy_stream_engine;
  import updy_pkg::*;

  localparam int LAT = 2;
  localparam int DPC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid, in_ready, in_mode;
  logic [47:0] in_y_a, in_y_b;
  logic        out_valid, out_ready;
  logic [47:0] out_y;
  logic        out_kind, out_chg_done, err_seq, busy;

  updy_stream_engine dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_y_a(in_y_a), .in_y_b(in_y_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_kind(out_kind), .out_chg_done(out_chg_done),
    .err_seq(err_seq), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [47:0] y;
    logic        kind;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  exp_t outLog[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int errSeen = 0;
  bit randReady = 0;
  bit chkLat = 0;

  // Reference model: "is a change open", its delta/mode, diagonals seen so far.
  bit          inChange = 0;
  logic [23:0] dRe = '0, dIm = '0;
  bit          dMode = 0;
  int          diagSeen = 0;
  bit          errPend = 0;
  bit          held = 0;
  logic [47:0] heldY;
  logic        heldKind, heldDone;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] cx(int re, int im);
    cplx_t c;
    c.re = 24'(re);
    c.im = 24'(im);
    return c;
  endfunction

  function automatic logic [23:0] refOp(logic [23:0] a, logic [23:0] b, bit sub);
    longint x, y, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    r = sub ? x - y : x + y;
`ifdef UPDY_SAT_EN
    if (r > 64'sd8388607)  r = 64'sd8388607;
    if (r < -64'sd8388608) r = -64'sd8388608;
`endif
    return r[23:0];
  endfunction

  task automatic modelAccept(input logic [47:0] a, input logic [47:0] b, input logic m,
                             output bit err);
    exp_t e;
    cplx_t ca, cb;
    ca = a;
    cb = b;
    err = 0;
    e.cyc = cyc;
    e.kind = 0;
    e.done = 0;
    if (b != '0) begin
      err = inChange;
      inChange = 1;
      dRe = cb.re;
      dIm = cb.im;
      dMode = m;
      diagSeen = 0;
      e.y = {refOp(ca.re, cb.re, !m), refOp(ca.im, cb.im, !m)};
      expQ.push_back(e);
    end else if (a != '0) begin
      e.kind = 1;
      if (!inChange) begin
        err = 1;
        e.y = a;
      end else begin
        e.y = {refOp(ca.re, dRe, dMode), refOp(ca.im, dIm, dMode)};
        diagSeen++;
        if (diagSeen == DPC) begin
          e.done = 1;
          inChange = 0;
        end
      end
      expQ.push_back(e);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (reset) begin
      held = 0;
      errPend = 0;
      inChange = 0;
      diagSeen = 0;
      expQ.delete();
    end else begin
      check("err_seq", err_seq, errPend);
      if (err_seq) errSeen++;
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_y", out_y, heldY);
        check("hold_kind", out_kind, heldKind);
        check("hold_done", out_chg_done, heldDone);
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          check("out_spurious", out_valid, 0);
        end else begin
          e = expQ.pop_front();
          check("out_y", out_y, e.y);
          check("out_kind", out_kind, e.kind);
          check("out_chg_done", out_chg_done, e.done);
          if (chkLat) check("latency", cyc - e.cyc, LAT);
          outLog.push_back('{out_y, out_kind, out_chg_done, cyc});
        end
      end
      held = out_valid && !out_ready;
      heldY = out_y;
      heldKind = out_kind;
      heldDone = out_chg_done;
      errPend = 0;
      if (in_valid && in_ready) modelAccept(in_y_a, in_y_b, in_mode, errPend);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (randReady) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic sendBeat(input logic [47:0] a, input logic [47:0] b, input logic m);
    bit acc;
    int guard;
    in_y_a = a;
    in_y_b = b;
    in_mode = m;
    in_valid = 1;
    guard = 0;
    do begin
      @(negedge clock);
      acc = in_ready;
      guard++;
      tick();
    end while (!acc && guard < 200);
    in_valid = 0;
    check("accept_timeout", acc, 1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((expQ.size() != 0 || out_valid) && guard < 1000) begin
      tick();
      guard++;
    end
    tick();
    check("drain_timeout", expQ.size(), 0);
  endtask

  task automatic logExpect(input string tag, input logic [47:0] y, input logic k, input logic d);
    exp_t o;
    if (outLog.size() == 0) begin
      check({tag, "_present"}, outLog.size(), 1);
    end else begin
      o = outLog.pop_front();
      check({tag, "_y"}, o.y, y);
      check({tag, "_kind"}, o.kind, k);
      check({tag, "_done"}, o.done, d);
    end
  endtask

  logic [47:0] bpA[4];
  logic [47:0] bpB[4];
  int nAcc;

  initial begin
    in_valid = 0; in_mode = 0; in_y_a = '0; in_y_b = '0; out_ready = 1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_kind", out_kind, 0);
    check("rst_out_done", out_chg_done, 0);
    check("rst_err_seq", err_seq, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clock);
    #1 reset = 0;
    tick();

    // add branch, back-to-back, fixed latency
    chkLat = 1;
    outLog.delete();
    sendBeat(cx(10, -4), cx(2, 1), 0);
    sendBeat(cx(20, 6), '0, 0);
    sendBeat(cx(5, 0), '0, 0);
    drain();
    logExpect("add_off", cx(8, -5), 0, 0);
    logExpect("add_d1", cx(22, 7), 1, 0);
    logExpect("add_d2", cx(7, 1), 1, 1);

    // remove branch
    sendBeat(cx(8, -5), cx(2, 1), 1);
    sendBeat(cx(22, 7), '0, 0);
    sendBeat(cx(7, 1), '0, 0);
    drain();
    logExpect("rem_off", cx(10, -4), 0, 0);
    logExpect("rem_d1", cx(20, 6), 1, 0);
    logExpect("rem_d2", cx(5, 0), 1, 1);
    chkLat = 0;

    // backpressure: 4 beats offered with output stalled for 5 cycles
    bpA[0] = cx(100, 50); bpB[0] = cx(3, -2);
    bpA[1] = cx(1, 1);    bpB[1] = '0;
    bpA[2] = cx(0, 9);    bpB[2] = '0;
    bpA[3] = cx(6, 6);    bpB[3] = '0;
    out_ready = 0;
    nAcc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (nAcc < 4);
      in_y_a = bpA[nAcc % 4];
      in_y_b = bpB[nAcc % 4];
      in_mode = 0;
      @(negedge clock);
      if (in_valid && in_ready) nAcc++;
      tick();
    end
    check("bp_accepts", nAcc, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    out_ready = 1;
    for (int i = nAcc; i < 4; i++) sendBeat(bpA[i], bpB[i], 0);
    drain();
    logExpect("bp_0", cx(97, 52), 0, 0);
    logExpect("bp_1", cx(4, -1), 1, 0);
    logExpect("bp_2", cx(3, 7), 1, 1);
    logExpect("bp_3", cx(6, 6), 1, 0);

    // sequencing errors and NOP
    errSeen = 0;
    sendBeat(cx(3, 3), '0, 0);
    sendBeat(cx(40, 40), cx(5, 5), 0);
    sendBeat(cx(10, 10), '0, 0);
    sendBeat(cx(50, 0), cx(1, 2), 1);
    sendBeat(cx(7, 7), '0, 0);
    sendBeat(cx(9, 9), '0, 0);
    sendBeat('0, '0, 0);
    drain();
    logExpect("seq_lone_diag", cx(3, 3), 1, 0);
    logExpect("seq_off", cx(35, 35), 0, 0);
    logExpect("seq_d1", cx(15, 15), 1, 0);
    logExpect("seq_reoff", cx(51, 2), 0, 0);
    logExpect("seq_d2", cx(6, 5), 1, 0);
    logExpect("seq_d3", cx(8, 7), 1, 1);
    check("nop_no_output", outLog.size(), 0);
    check("seq_err_count", errSeen, 2);
    check("seq_idle_busy", busy, 0);

    // overflow at the positive edge of the range
    sendBeat(cx(24'h7FFFFF, 0), cx(-1, 0), 0);
    sendBeat(cx(1, 1), '0, 0);
    sendBeat(cx(2, 2), '0, 0);
    drain();
`ifdef UPDY_SAT_EN
    logExpect("ovf_off", cx(24'h7FFFFF, 0), 0, 0);
`else
    logExpect("ovf_off", cx(24'h800000, 0), 0, 0);
`endif
    logExpect("ovf_d1", cx(0, 1), 1, 0);
    logExpect("ovf_d2", cx(1, 2), 1, 1);

    // asynchronous reset with beats in flight
    out_ready = 0;
    sendBeat(cx(1, 2), cx(3, 4), 0);
    sendBeat(cx(5, 5), '0, 0);
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clock);
    #1 reset = 0;
    out_ready = 1;
    tick();
    outLog.delete();
    errSeen = 0;
    sendBeat(cx(12, 12), cx(2, 2), 0);
    sendBeat(cx(4, 4), '0, 0);
    sendBeat(cx(1, 1), '0, 0);
    drain();
    logExpect("post_rst_off", cx(10, 10), 0, 0);
    logExpect("post_rst_d1", cx(6, 6), 1, 0);
    logExpect("post_rst_d2", cx(3, 3), 1, 1);
    check("post_rst_err", errSeen, 0);

    // randomized beats with random output stalls
    randReady = 1;
    for (int n = 0; n < 400; n++) begin
      logic [47:0] a, b;
      int r;
      r = $urandom_range(0, 9);
      a = {24'($urandom), 24'($urandom)};
      b = {24'($urandom), 24'($urandom)};
      if ($urandom_range(0, 3) == 0) a[47:24] = 24'h7FFFFF;
      if ($urandom_range(0, 3) == 0) b[23:0] = 24'h800000;
      if (r < 3) begin
        if (b == '0) b = 48'd1;
      end else if (r < 9) begin
        b = '0;
        if (a == '0) a = 48'd1;
      end else begin
        a = '0;
        b = '0;
      end
      sendBeat(a, b, 1'($urandom_range(0, 1)));
    end
    drain();
    randReady = 0;
    out_ready = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
